keypad_scan: RTL and testbench
==============================

Name: keypad_scan

Overview:
- Upstream stage of the piano tone path. Scans a 4x4 active-low matrix keypad, synchronises and debounces the column inputs, and presents one clean key as a one-hot 16-bit code.
- Its output key_out feeds the beeper stage's key input directly. That stage maps one-hot codes to tone periods, so key_out is always zero or exactly one hot bit.

Parameters:
- SCAN_CYCLES, 50000, clocks per row slot (1 ms at 50 MHz); must be >= 4.
- DEBOUNCE_SCANS, 5, identical consecutive full-matrix frames required before key_out updates; must be >= 2.
- CNT_WIDTH, 16, width of the slot counter; 2**CNT_WIDTH > SCAN_CYCLES.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset. Synchronous and active-high despite the name.
- col_in  input  4  keypad columns, asynchronous, pulled up; 0 = key closed on the driven row.
- row_out  output  4  keypad rows, active-low, exactly one row low at a time.
- key_out  output  16  debounced one-hot key, bit index = row*4+col; 0 = no key.
- key_change  output  1  one-cycle pulse when key_out takes a new value.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Reset is sampled on the rising edge of clk with rst_n=1.
- Reset values:
  - row_out=4'b1110 (row 0 driven).
  - key_out=0, key_change=0.
  - Slot counter=0, row index=0.
  - Frame, previous-frame and stable-count registers=0.
  - Synchroniser flops=4'b1111.
- col_in passes through a 2-flop synchroniser. It is then inverted, so 1 = pressed.
- Row FSM: states ROW0..ROW3, with row_out=~(4'b0001<<row).
  - Slot counter counts 0..SCAN_CYCLES-1.
  - On the cycle where the counter = SCAN_CYCLES-1, the synchronised columns are written into frame bits [row*4+3:row*4]. In the same cycle the counter wraps to 0 and the row advances; ROW3 wraps to ROW0.
  - Each row therefore gets SCAN_CYCLES-1 cycles of settling, which covers the synchroniser delay.
- Frame completion: the ROW3 sample cycle completes a frame. On the next cycle the assembled 16-bit frame is compared with prev_frame, and then:
  - Equal: stable_cnt increments, saturating at DEBOUNCE_SCANS-1.
  - Not equal: stable_cnt=0.
  - prev_frame is loaded with the new frame in both cases.
- Output update: when stable_cnt reaches DEBOUNCE_SCANS-1 (DEBOUNCE_SCANS identical consecutive frames), the priority-encoded one-hot of the frame is computed.
  - The lowest set index wins; an all-zero frame gives 0.
  - If that value differs from key_out, key_out is loaded and key_change=1 for exactly that cycle.
  - While saturated, later identical frames re-evaluate to the same value, so there is no further pulse.
- Multiple keys pressed: only the lowest index is reported. Releasing it while another key stays held moves key_out to the next lowest index after debounce.
- Bounce: any frame difference resets stable_cnt. key_out holds its old value until the frame has been stable again for DEBOUNCE_SCANS frames.
- Latency: a press stable from a frame start is reported DEBOUNCE_SCANS frames later, plus 1 cycle.
- Reset mid-scan: everything returns to reset values on the next edge. Partial frame data is discarded and key_out drops to 0. key_change does not pulse for the reset-induced change.
- Counter widths: no truncation permitted; SCAN_CYCLES-1 must fit in CNT_WIDTH.

Test Plan (SCAN_CYCLES=4, DEBOUNCE_SCANS=3, so frame = 16 cycles):
- Reset then idle, col_in=4'hF -> row_out cycles 1110,1101,1011,0111 every 4 clocks; key_out=0; key_change never asserts.
- Model key (row 2, col 1) held steady: col_in[1]=0 whenever row_out=1011 -> key_out=16'h0200 after the 3rd identical frame, with a single key_change pulse on that cycle.
- Same key bounces (toggles each frame) for 4 frames, then holds -> key_out stays 0 during bouncing; becomes 16'h0200 exactly 3 frames after bouncing stops.
- Keys 5 and 12 held together -> key_out=16'h0020. Release key 5 -> after 3 frames key_out=16'h1000 with one key_change pulse. Release all -> key_out=0 with one pulse.
- rst_n=1 for one cycle in the middle of the ROW1 slot while key_out=16'h0200 -> next cycle key_out=0, row_out=1110, no key_change; the key is re-reported after a further 3 clean frames.
- Glitch on col_in shorter than 2 cycles, not coinciding with a sample cycle -> no frame change, key_out unchanged.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: row strobe, 2-flop column sync, frame debounce,
// lowest-index one-hot key output with a one-cycle change pulse.
module keypad_scan #(
  parameter int SCAN_CYCLES    = 50000,
  parameter int DEBOUNCE_SCANS = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic [15:0] key_out,
  output logic        key_change
);

  localparam int SW = $clog2(DEBOUNCE_SCANS);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST   = CNT_WIDTH'(SCAN_CYCLES - 1);
  localparam logic [SW-1:0]        STABLE_MAX = SW'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {ROW0 = 2'd0, ROW1 = 2'd1, ROW2 = 2'd2, ROW3 = 2'd3} row_e;

  row_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]           sync1_q, sync2_q;
  logic [15:0]          frame_q, frame_d;
  logic                 frame_done_q, frame_done_d;
  logic [15:0]          prev_q, prev_d;
  logic [SW-1:0]        stable_q, stable_d;
  logic [15:0]          key_q, key_d;
  logic                 change_q, change_d;
  logic [1:0]           row_idx;
  logic [15:0]          onehot;

  // rst_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= ROW0;
      cnt_q        <= '0;
      sync1_q      <= 4'b1111;
      sync2_q      <= 4'b1111;
      frame_q      <= '0;
      frame_done_q <= 1'b0;
      prev_q       <= '0;
      stable_q     <= '0;
      key_q        <= '0;
      change_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sync1_q      <= col_in;
      sync2_q      <= sync1_q;
      frame_q      <= frame_d;
      frame_done_q <= frame_done_d;
      prev_q       <= prev_d;
      stable_q     <= stable_d;
      key_q        <= key_d;
      change_q     <= change_d;
    end
  end

  assign row_idx = state_q;

  // Row strobe: sample the settled columns on the last cycle of each slot.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_WIDTH'(1);
    frame_d      = frame_q;
    frame_done_d = 1'b0;
    row_out      = ~(4'b0001 << row_idx);
    if (cnt_q == CNT_LAST) begin
      cnt_d                          = '0;
      frame_d[{row_idx, 2'b00} +: 4] = ~sync2_q;
      frame_done_d                   = (state_q == ROW3);
      case (state_q)
        ROW0:    state_d = ROW1;
        ROW1:    state_d = ROW2;
        ROW2:    state_d = ROW3;
        default: state_d = ROW0;
      endcase
    end
  end

  // Lowest set bit of the frame; zero frame gives zero.
  assign onehot = frame_q & (~frame_q + 16'd1);

  always_comb begin
    prev_d   = prev_q;
    stable_d = stable_q;
    key_d    = key_q;
    change_d = 1'b0;
    if (frame_done_q) begin
      prev_d = frame_q;
      if (frame_q == prev_q) begin
        if (stable_q != STABLE_MAX) stable_d = stable_q + SW'(1);
      end else begin
        stable_d = '0;
      end
      if ((stable_d == STABLE_MAX) && (onehot != key_q)) begin
        key_d    = onehot;
        change_d = 1'b1;
      end
    end
  end

  assign key_out    = key_q;
  assign key_change = change_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a 4-cycle slot and 3-frame debounce;
// a keypad model closes columns for held keys on the currently driven row.
module tb_keypad_scan;

  logic        clk;
  logic        rst_n;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] key_out;
  logic        key_change;

  logic [15:0] held;
  logic [3:0]  glitch;
  int          n_checks;
  int          n_fail;
  int          pulses;
  int          p0;

  keypad_scan #(
    .SCAN_CYCLES    (4),
    .DEBOUNCE_SCANS (3),
    .CNT_WIDTH      (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .col_in     (col_in),
    .row_out    (row_out),
    .key_out    (key_out),
    .key_change (key_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (row_out[r] == 1'b0) col_in = col_in & ~held[r*4 +: 4];
    end
    col_in = col_in ^ glitch;
  end

  always @(negedge clk) begin
    if (key_change === 1'b1) pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    held   = '0;
    glitch = '0;
    rst_n  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
  endtask

  logic [3:0] exp_rows [4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pulses   = 0;
    held     = '0;
    glitch   = '0;
    rst_n    = 1'b1;
    exp_rows = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // Idle scan after reset
    do_reset();
    p0 = pulses;
    check("rst_row_out", 32'(row_out), 32'h0000_000E);
    check("rst_key_out", 32'(key_out), 32'h0);
    check("rst_key_change", 32'(key_change), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(4);
      check("idle_row_seq", 32'(row_out), 32'(exp_rows[i]));
    end
    step(48);
    check("idle_key_out", 32'(key_out), 32'h0);
    check("idle_no_pulse", 32'(pulses - p0), 32'h0);

    // Key 9 (row 2, col 1) held from the first frame
    do_reset();
    p0   = pulses;
    held = 16'h0200;
    step(48);
    check("hold_before_debounce", 32'(key_out), 32'h0);
    step(1);
    check("hold_key_out", 32'(key_out), 32'h0000_0200);
    check("hold_pulse", 32'(key_change), 32'h1);
    step(1);
    check("hold_pulse_one_cycle", 32'(key_change), 32'h0);
    step(32);
    check("hold_steady", 32'(key_out), 32'h0000_0200);
    check("hold_pulse_count", 32'(pulses - p0), 32'h1);

    // Bounce on alternate frames, then settle
    do_reset();
    p0   = pulses;
    held = 16'h0200;
    step(16);
    held = 16'h0000;
    step(16);
    held = 16'h0200;
    step(16);
    held = 16'h0000;
    step(16);
    held = 16'h0200;
    check("bounce_key_out", 32'(key_out), 32'h0);
    step(48);
    check("bounce_settling", 32'(key_out), 32'h0);
    check("bounce_no_pulse", 32'(pulses - p0), 32'h0);
    step(1);
    check("bounce_key_out_final", 32'(key_out), 32'h0000_0200);
    check("bounce_pulse", 32'(key_change), 32'h1);

    // Keys 5 and 12 together, then release 5, then release all
    do_reset();
    p0   = pulses;
    held = 16'h1020;
    step(49);
    check("multi_lowest", 32'(key_out), 32'h0000_0020);
    check("multi_pulse", 32'(key_change), 32'h1);
    step(15);
    held = 16'h1000;
    step(48);
    check("rel5_hold_old", 32'(key_out), 32'h0000_0020);
    check("rel5_pulse_count", 32'(pulses - p0), 32'h1);
    step(1);
    check("rel5_key_out", 32'(key_out), 32'h0000_1000);
    check("rel5_pulse", 32'(key_change), 32'h1);
    step(15);
    held = 16'h0000;
    step(48);
    check("relall_hold_old", 32'(key_out), 32'h0000_1000);
    check("relall_pulse_count", 32'(pulses - p0), 32'h2);
    step(1);
    check("relall_key_out", 32'(key_out), 32'h0);
    check("relall_pulse", 32'(key_change), 32'h1);
    step(1);
    check("relall_pulse_one_cycle", 32'(key_change), 32'h0);
    check("relall_total_pulses", 32'(pulses - p0), 32'h3);

    // Reset in the middle of the ROW1 slot while key 9 is reported
    do_reset();
    held = 16'h0200;
    step(49);
    check("midrst_pre_key", 32'(key_out), 32'h0000_0200);
    step(4);
    check("midrst_in_row1", 32'(row_out), 32'h0000_000D);
    p0    = pulses;
    rst_n = 1'b1;
    step(1);
    rst_n = 1'b0;
    check("midrst_key_out", 32'(key_out), 32'h0);
    check("midrst_row_out", 32'(row_out), 32'h0000_000E);
    check("midrst_key_change", 32'(key_change), 32'h0);
    step(48);
    check("midrst_before_rereport", 32'(key_out), 32'h0);
    check("midrst_no_pulse", 32'(pulses - p0), 32'h0);
    step(1);
    check("midrst_rereport", 32'(key_out), 32'h0000_0200);
    check("midrst_rereport_pulse", 32'(key_change), 32'h1);

    // One-cycle glitch on key 5's column at the start of every ROW1 slot
    step(3);
    check("glitch_in_row1", 32'(row_out), 32'h0000_000D);
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      glitch = 4'b0010;
      step(1);
      glitch = 4'b0000;
      step(15);
    end
    step(16);
    check("glitch_key_out", 32'(key_out), 32'h0000_0200);
    check("glitch_no_pulse", 32'(pulses - p0), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
